// File: rtl/eth_tx_pkg.sv
// Shared state encoding and header/gap sizing for the Ethernet TX frame sequencer.
package eth_tx_pkg;

   typedef enum logic [1:0] {IDLE, HEAD, DATA, IFG} tx_state_t;

   // Header byte budget; the MAC portion carries preamble and SFD.
   localparam int MAC_HEAD_N = 26;
   localparam int IP_HEAD_N  = 20;
   localparam int UDP_HEAD_N = 8;
   localparam int ETH_HEAD_N = MAC_HEAD_N + IP_HEAD_N + UDP_HEAD_N;

   localparam int IFG_N_DEF  = 12;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/eth_tx_head_shift.sv
// Header load/shift register: presents the next header bytes, first wire byte in lane 0.
// Latency 0 from register to beat; advances one beat per accepted cycle, holds otherwise.
module eth_tx_head_shift #(
   parameter int DATA_W = 16,
   parameter int HEAD_N = 54,
   parameter int HEAD_W = HEAD_N * 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [HEAD_W-1:0] head,
   output logic [DATA_W-1:0] beat_data,
   output logic              first,
   output logic              done
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int BEATS  = HEAD_N / KEEP_W;
   localparam int BEAT_W = $clog2(BEATS + 1);

   generate
      if (HEAD_N % KEEP_W != 0) begin : g_bad_head
         $error("HEAD_N must be a whole number of bus beats");
      end
   endgenerate

   logic [HEAD_W-1:0] head_q;
   logic [BEAT_W-1:0] beat_q;
   logic              first_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         beat_q  <= '0;
         first_q <= 1'b0;
      end else if (load) begin
         head_q  <= head;
         beat_q  <= BEAT_W'(BEATS - 1);
         first_q <= 1'b1;
      end else if (advance) begin
         head_q  <= head_q << DATA_W;
         first_q <= 1'b0;
         if (beat_q != '0) begin
            beat_q <= beat_q - 1'b1;
         end
      end
   end

   // Header is MSB-first on the wire, bus lanes are LSB-first.
   for (genvar k = 0; k < KEEP_W; k++) begin : g_lane
      assign beat_data[8*k +: 8] = head_q[HEAD_W-1-8*k -: 8];
   end

   assign first = first_q;
   assign done  = (beat_q == '0);

endmodule

// File: rtl/eth_tx_sched.sv
// Frame sequencer: header beats, payload pass-through, inter-frame gap. Option: ETH_TX_SCHED_UNDERRUN_ERR_EN.
// First header beat 1 cycle after start, payload combinational; tx_ready_i stalls all, app held until header done.
module eth_tx_sched
   import eth_tx_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int KEEP_W    = DATA_W / 8,
   parameter int LEN_W     = $clog2(KEEP_W + 1),
   parameter int PKT_LEN_W = 16,
   parameter int HEAD_N    = ETH_HEAD_N,
   parameter int HEAD_W    = HEAD_N * 8,
   parameter int IFG_N     = IFG_N_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [HEAD_W-1:0]    head_i,
   input  logic                 app_valid_i,
   input  logic [DATA_W-1:0]    app_data_i,
   input  logic [LEN_W-1:0]     app_len_i,
   input  logic [PKT_LEN_W-1:0] app_pkt_len_i,
   output logic                 app_ready_o,
   output logic                 tx_valid_o,
   output logic [DATA_W-1:0]    tx_data_o,
   output logic [LEN_W-1:0]     tx_len_o,
   output logic                 tx_start_o,
   output logic                 tx_last_o,
   input  logic                 tx_ready_i,
   output logic                 err_o
);

   localparam int               IFG_CYC = ceil_div(IFG_N, KEEP_W);
   localparam int               IFG_W   = $clog2(IFG_CYC + 1);
   localparam logic [LEN_W-1:0] KEEP_L  = LEN_W'(KEEP_W);

   tx_state_t            state_q;
   logic [PKT_LEN_W-1:0] rem_q;
   logic [IFG_W-1:0]     ifg_q;
   logic                 err_q;

   logic [DATA_W-1:0]    head_data;
   logic                 head_first;
   logic                 head_done;
   logic                 start_ok;
   logic                 zero_len;
   logic                 head_adv;
   logic [PKT_LEN_W-1:0] app_len_ext;
   logic [LEN_W-1:0]     len_clamp;
   logic                 last_beat;
   logic                 data_xfer;
   logic                 len_err;
   logic                 underrun;

   eth_tx_head_shift #(
      .DATA_W (DATA_W),
      .HEAD_N (HEAD_N),
      .HEAD_W (HEAD_W)
   ) u_head_shift (
      .clk       (clk),
      .reset     (reset),
      .load      (start_ok),
      .advance   (head_adv),
      .head      (head_i),
      .beat_data (head_data),
      .first     (head_first),
      .done      (head_done)
   );

   assign start_ok    = (state_q == IDLE) && app_valid_i && (app_pkt_len_i != '0);
   assign zero_len    = (state_q == IDLE) && app_valid_i && (app_pkt_len_i == '0);
   assign head_adv    = (state_q == HEAD) && tx_ready_i;
   assign app_len_ext = PKT_LEN_W'(app_len_i);
   assign len_clamp   = (app_len_ext < rem_q) ? app_len_i : rem_q[LEN_W-1:0];
   assign last_beat   = app_valid_i && (app_len_ext >= rem_q);
   assign data_xfer   = (state_q == DATA) && app_valid_i && tx_ready_i;

   // Short beats are only legal at the end of the frame; overlong beats are clamped but flagged.
   assign len_err = data_xfer && ((!last_beat && (app_len_i < KEEP_L)) || (app_len_ext > rem_q));

`ifdef ETH_TX_SCHED_UNDERRUN_ERR_EN
   assign underrun = (state_q == DATA) && tx_ready_i && !app_valid_i;
`else
   assign underrun = 1'b0;
`endif

   always_comb begin
      app_ready_o = 1'b0;
      tx_valid_o  = 1'b0;
      tx_data_o   = '0;
      tx_len_o    = '0;
      tx_start_o  = 1'b0;
      tx_last_o   = 1'b0;
      case (state_q)
         HEAD: begin
            tx_valid_o = 1'b1;
            tx_data_o  = head_data;
            tx_len_o   = KEEP_L;
            tx_start_o = head_first;
         end
         DATA: begin
            tx_valid_o  = app_valid_i;
            app_ready_o = tx_ready_i;
            tx_data_o   = app_data_i;
            tx_len_o    = len_clamp;
            tx_last_o   = last_beat;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         ifg_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (zero_len || len_err || underrun) begin
            err_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  rem_q   <= app_pkt_len_i;
                  state_q <= HEAD;
               end
            end
            HEAD: begin
               if (tx_ready_i && head_done) begin
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (data_xfer) begin
                  rem_q <= rem_q - PKT_LEN_W'(len_clamp);
                  if (last_beat) begin
                     ifg_q   <= IFG_W'(IFG_CYC - 1);
                     state_q <= IFG;
                  end
               end
            end
            IFG: begin
               if (ifg_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  ifg_q <= ifg_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: header order, payload clamping, stalls, IFG spacing, reset abort, errors.
module tb_eth_tx_sched;

   localparam int DATA_W    = 16;
   localparam int KEEP_W    = 2;
   localparam int LEN_W     = 2;
   localparam int PKT_LEN_W = 16;
   localparam int HEAD_N    = 54;
   localparam int HEAD_W    = HEAD_N * 8;
   localparam int IFG_N     = 12;
   localparam int IFG_CYC   = 6;

`ifdef ETH_TX_SCHED_UNDERRUN_ERR_EN
   localparam logic UNDERRUN_EN = 1'b1;
`else
   localparam logic UNDERRUN_EN = 1'b0;
`endif

   logic                 clk;
   logic                 reset;
   logic [HEAD_W-1:0]    head_i;
   logic                 app_valid;
   logic [DATA_W-1:0]    app_data;
   logic [LEN_W-1:0]     app_len;
   logic [PKT_LEN_W-1:0] app_pkt_len;
   logic                 app_ready;
   logic                 tx_valid;
   logic [DATA_W-1:0]    tx_data;
   logic [LEN_W-1:0]     tx_len;
   logic                 tx_start;
   logic                 tx_last;
   logic                 tx_ready;
   logic                 err;

   int n_assert = 0;
   int n_fail   = 0;

   eth_tx_sched #(
      .DATA_W    (DATA_W),
      .KEEP_W    (KEEP_W),
      .LEN_W     (LEN_W),
      .PKT_LEN_W (PKT_LEN_W),
      .HEAD_N    (HEAD_N),
      .HEAD_W    (HEAD_W),
      .IFG_N     (IFG_N)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .head_i        (head_i),
      .app_valid_i   (app_valid),
      .app_data_i    (app_data),
      .app_len_i     (app_len),
      .app_pkt_len_i (app_pkt_len),
      .app_ready_o   (app_ready),
      .tx_valid_o    (tx_valid),
      .tx_data_o     (tx_data),
      .tx_len_o      (tx_len),
      .tx_start_o    (tx_start),
      .tx_last_o     (tx_last),
      .tx_ready_i    (tx_ready),
      .err_o         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after the edge; checks run 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [HEAD_W-1:0] mk_head(input logic [7:0] base);
      logic [HEAD_W-1:0] h;
      h = '0;
      for (int i = 0; i < HEAD_N; i++) begin
         h[HEAD_W-1-8*i -: 8] = base + 8'(i);
      end
      return h;
   endfunction

   function automatic logic [7:0] pay_byte(input logic [7:0] base, input int j);
      return 8'hA0 + base + 8'(j);
   endfunction

   task automatic set_beat(input logic [7:0] base, input int p, input int plen);
      if (plen - 2 * p >= 2) begin
         app_len  = 2'd2;
         app_data = {pay_byte(base, 2 * p + 1), pay_byte(base, 2 * p)};
      end else begin
         app_len  = 2'd1;
         app_data = {8'hEE, pay_byte(base, 2 * p)};
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, tx_valid, 0);
      chk({tag, "_data"}, tx_data, 0);
      chk({tag, "_len"}, tx_len, 0);
      chk({tag, "_start"}, tx_start, 0);
      chk({tag, "_last"}, tx_last, 0);
      chk({tag, "_ready"}, app_ready, 0);
   endtask

   task automatic check_head(input int b, input logic [15:0] exp);
      chk("head_valid", tx_valid, 1);
      chk("head_data", tx_data, exp);
      chk("head_len", tx_len, 2);
      chk("head_start", tx_start, (b == 0) ? 1 : 0);
      chk("head_last", tx_last, 0);
      chk("head_app_ready", app_ready, 0);
   endtask

   task automatic check_pay(input logic [15:0] exp_data, input int exp_len, input bit exp_last);
      chk("pay_valid", tx_valid, 1);
      chk("pay_data", tx_data, exp_data);
      chk("pay_len", tx_len, exp_len);
      chk("pay_last", tx_last, exp_last);
      chk("pay_start", tx_start, 0);
   endtask

   task automatic send_frame(input int plen, input logic [7:0] base, input bit stall,
                             input int pre_idle, input int gap_at, input int abort_at);
      int          nbeats;
      int          exp_len;
      logic [15:0] exp;
      nbeats      = (plen + 1) / 2;
      head_i      = mk_head(base);
      app_pkt_len = 16'(plen);
      app_valid   = 1'b1;
      tx_ready    = 1'b1;
      set_beat(base, 0, plen);
      repeat (pre_idle) begin
         #1;
         chk("ifg_valid", tx_valid, 0);
         chk("ifg_app_ready", app_ready, 0);
         tick();
      end
      #1;
      chk("idle_valid", tx_valid, 0);
      chk("idle_app_ready", app_ready, 0);
      tick();
      for (int b = 0; b < HEAD_N / KEEP_W; b++) begin
         exp = {base + 8'(2 * b + 1), base + 8'(2 * b)};
         if (b == abort_at) return;
         if (stall && (b % 2 == 0)) begin
            tx_ready = 1'b0;
            #1;
            check_head(b, exp);
            tick();
            tx_ready = 1'b1;
         end
         #1;
         check_head(b, exp);
         tick();
      end
      for (int p = 0; p < nbeats; p++) begin
         set_beat(base, p, plen);
         exp_len = (plen - 2 * p >= 2) ? 2 : 1;
         exp = (exp_len == 2) ? {pay_byte(base, 2 * p + 1), pay_byte(base, 2 * p)}
                              : {8'hEE, pay_byte(base, 2 * p)};
         if (p == gap_at) begin
            app_valid = 1'b0;
            #1;
            chk("gap_valid", tx_valid, 0);
            chk("gap_last", tx_last, 0);
            tick();
            app_valid = 1'b1;
         end
         if (stall) begin
            tx_ready = 1'b0;
            #1;
            check_pay(exp, exp_len, p == nbeats - 1);
            chk("pay_app_ready_stall", app_ready, 0);
            tick();
            tx_ready = 1'b1;
         end
         #1;
         check_pay(exp, exp_len, p == nbeats - 1);
         chk("pay_app_ready", app_ready, 1);
         tick();
      end
      app_valid = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      head_i      = '0;
      app_valid   = 1'b0;
      app_data    = '0;
      app_len     = '0;
      app_pkt_len = '0;
      tx_ready    = 1'b0;
      #1;
      check_zero("reset");
      chk("reset_err", err, 0);
      tick();
      tick();
      reset = 1'b0;

      send_frame(6, 8'h10, 1'b0, 0, -1, -1);
      send_frame(5, 8'h40, 1'b0, IFG_CYC, -1, -1);
      #1;
      chk("err_len5", err, 0);
      send_frame(4, 8'h70, 1'b1, IFG_CYC, -1, -1);
      #1;
      chk("err_stall", err, 0);
      send_frame(6, 8'h90, 1'b0, IFG_CYC, 1, -1);
      #1;
      chk("err_underrun", err, UNDERRUN_EN);

      // Abort mid-header: outputs must drop without waiting for a clock edge.
      send_frame(8, 8'hB0, 1'b0, IFG_CYC, -1, 10);
      reset = 1'b1;
      #1;
      check_zero("abort");
      chk("abort_err", err, 0);
      tick();
      reset = 1'b0;
      send_frame(4, 8'hC8, 1'b0, 0, -1, -1);
      #1;
      chk("err_after_abort", err, 0);

      app_valid   = 1'b1;
      app_pkt_len = '0;
      for (int i = 0; i < IFG_CYC + 2; i++) begin
         #1;
         chk("zlen_valid", tx_valid, 0);
         chk("zlen_app_ready", app_ready, 0);
         tick();
      end
      #1;
      chk("zlen_err", err, 1);
      app_valid = 1'b0;
      tick();
      tick();
      tick();
      #1;
      chk("zlen_err_sticky", err, 1);
      chk("zlen_idle_valid", tx_valid, 0);
      reset = 1'b1;
      #1;
      chk("err_cleared", err, 0);
      tick();
      reset = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Sequences one Ethernet frame onto the narrow PCS-facing bus: first the prebuilt header (MAC + IPv4 + UDP, preamble included), then the application payload, then an inter-frame gap.
- Sits between the combinational header builders and the PCS/PMA.
- Backpressures the application until the header has been fully sent.

Parameters:
- DATA_W, 16: bus width in bits.
- KEEP_W, DATA_W/8: bytes per beat.
- LEN_W, $clog2(KEEP_W+1): width of a byte-count field.
- PKT_LEN_W, 16: width of the payload length.
- HEAD_N, 54: header bytes (26 MAC + 20 IP + 8 UDP). Elaboration error if HEAD_N % KEEP_W != 0.
- HEAD_W, HEAD_N*8: header width in bits.
- IFG_N, 12: inter-frame gap in bytes; the gap lasts ceil(IFG_N/KEEP_W) cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- head_i  in  HEAD_W  full header; first wire byte is head_i[HEAD_W-1 -: 8].
- app_valid_i  in  1  application beat valid.
- app_data_i  in  DATA_W  payload; first byte in lane 0 = [7:0].
- app_len_i  in  LEN_W  valid bytes in beat, lanes 0..len-1.
- app_pkt_len_i  in  PKT_LEN_W  total payload bytes; sampled at frame start.
- app_ready_o  out  1  beat accepted when app_valid_i && app_ready_o.
- tx_valid_o  out  DATA_W/1  see tx_* below; width 1.
- tx_data_o  out  DATA_W  beat to PCS.
- tx_len_o  out  LEN_W  valid bytes in beat.
- tx_start_o  out  1  first header beat.
- tx_last_o  out  1  final payload beat.
- tx_ready_i  in  1  PCS accepts the beat.
- err_o  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- States: IDLE, HEAD, DATA, IFG. Reset forces IDLE.
- Reset values: all outputs 0; shift register, counters and err_o cleared.
- Reset mid-frame aborts immediately with no tx_last_o; the next frame starts cleanly.
- IDLE:
  - app_ready_o=0, tx_valid_o=0.
  - If app_valid_i && app_pkt_len_i!=0: latch head_i into the shift register, rem_q=app_pkt_len_i, beat_q=HEAD_N/KEEP_W-1, go to HEAD. The first app beat is held, not consumed.
  - If app_valid_i && app_pkt_len_i==0: frame is ignored and err_o is set.
- HEAD:
  - tx_valid_o=1, tx_len_o=KEEP_W, tx_data_o = next KEEP_W header bytes (byte order reversed into lanes), tx_start_o=1 on the first beat only.
  - On tx_ready_i: shift by DATA_W and decrement beat_q; at beat_q==0 go to DATA.
  - A stall (tx_ready_i=0) holds all outputs stable.
- DATA (combinational pass-through):
  - tx_valid_o=app_valid_i, app_ready_o=tx_ready_i, tx_data_o=app_data_i.
  - tx_len_o = min(app_len_i, rem_q); tx_last_o = app_valid_i && (app_len_i >= rem_q).
  - On handshake, rem_q -= tx_len_o (16-bit, no wrap possible).
  - On handshake with tx_last_o, go to IFG.
  - app_len_i < KEEP_W on a non-last beat, or app_len_i > rem_q, sets err_o. The beat is still sent with the clamped length.
  - app_valid_i low (underrun) gives tx_valid_o=0 with no error here (see the optional feature).
- IFG:
  - Outputs idle for ceil(IFG_N/KEEP_W) cycles (6 at default), counted by ifg_q, then go to IDLE.
  - A new start is not accepted before the IDLE cycle, so minimum frame-to-frame spacing is 6 IFG cycles + 1 IDLE cycle.
- Header latency: first header beat appears the cycle after the IDLE start cycle.

Optional Feature:
- Macro ETH_TX_SCHED_UNDERRUN_ERR_EN.
- Defined: a DATA-state cycle with tx_ready_i && !app_valid_i sets err_o, because Ethernet cannot tolerate mid-frame gaps.
- Undefined: underrun stalls silently and err_o is set only by the length violations above.

Decomposition:
- Package eth_tx_pkg holds:
  - the state enum (IDLE/HEAD/DATA/IFG);
  - the HEAD_N components (MAC_HEAD_N=26, IP_HEAD_N=20, UDP_HEAD_N=8);
  - the IFG_N=12 default.
- Sub-module eth_tx_head_shift holds:
  - the HEAD_W load/shift register;
  - the lane byte-reversal;
  - the beat counter with its done flag.
- The FSM, length arithmetic and IFG counter stay in eth_tx_sched.

Test Plan:
- Payload len 6, tx_ready_i=1, app beats len 2 ×3 → 27 header beats (tx_start_o on beat 1 only), then 3 payload beats with last on the 3rd (tx_len_o=2), then 6 idle cycles.
- Payload len 5 → payload beats len 2,2,1; last beat tx_len_o=1, upper lane ignored; err_o=0.
- tx_ready_i toggles 1/0 during HEAD and DATA → outputs stable while stalled; app_ready_o mirrors tx_ready_i only in DATA; no beat is lost or duplicated.
- Reset asserted at header beat 10 → outputs 0 asynchronously; after release, a new frame of len 4 starts cleanly with full header.
- app_pkt_len_i=0 with app_valid_i=1 → no transmission, err_o=1 and sticky until reset.
- Macro defined: app_valid_i dropped for 1 cycle mid-payload with tx_ready_i=1 → err_o=1. Macro undefined: same stimulus leaves err_o=0.
